zeroheti_apb_arb: RTL and testbench

ZEROHETI_APB_ARB -- requirements
Module: zeroheti_apb_arb

---
 rtl/zeroheti_apb_arb.sv | 142 ++++++++++++++
 tb/tb_zeroheti_apb_arb.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zeroheti_apb_arb.sv
// Two-manager to one-subordinate APB arbiter with round-robin grant.
// Optional subordinate wait-state timeout enabled by defining APB_ARB_TIMEOUT_EN.
module zeroheti_apb_arb #(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [1:0]                mgr_psel_i,
  input  logic [1:0]                mgr_penable_i,
  input  logic [1:0]                mgr_pwrite_i,
  input  logic [1:0][AddrWidth-1:0] mgr_paddr_i,
  input  logic [1:0][DataWidth-1:0] mgr_pwdata_i,
  output logic [1:0][DataWidth-1:0] mgr_prdata_o,
  output logic [1:0]                mgr_pready_o,
  output logic [1:0]                mgr_pslverr_o,
  output logic                      sub_psel_o,
  output logic                      sub_penable_o,
  output logic                      sub_pwrite_o,
  output logic [AddrWidth-1:0]      sub_paddr_o,
  output logic [DataWidth-1:0]      sub_pwdata_o,
  input  logic [DataWidth-1:0]      sub_prdata_i,
  input  logic                      sub_pready_i,
  input  logic                      sub_pslverr_i,
  output logic                      timeout_o,
  output logic [1:0]                state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   gnt_q, gnt_d;
  logic   last_q, last_d;
  logic   timeout_hit;

  // Managers are held in their access phase by pready alone, so penable
  // carries no information the arbiter needs.
  logic [1:0] unused_penable;
  assign unused_penable = mgr_penable_i;

  assign state_o = state_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    last_d        = last_q;
    sub_psel_o    = 1'b0;
    sub_penable_o = 1'b0;
    sub_pwrite_o  = 1'b0;
    sub_paddr_o   = '0;
    sub_pwdata_o  = '0;
    mgr_prdata_o  = '0;
    mgr_pready_o  = '0;
    mgr_pslverr_o = '0;
    timeout_o     = 1'b0;

    if (state_q != IDLE) begin
      sub_psel_o   = 1'b1;
      sub_pwrite_o = mgr_pwrite_i[gnt_q];
      sub_paddr_o  = mgr_paddr_i[gnt_q];
      sub_pwdata_o = mgr_pwdata_i[gnt_q];
    end

    case (state_q)
      IDLE: begin
        if (|mgr_psel_i) begin
          state_d = SETUP;
          // On a tie the manager that did not win last time gets the bus.
          gnt_d   = (&mgr_psel_i) ? ~last_q : mgr_psel_i[1];
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        sub_penable_o = 1'b1;
        if (sub_pready_i || timeout_hit) begin
          state_d   = IDLE;
          last_d    = gnt_q;
          timeout_o = timeout_hit;
          // A manager that abandoned its request gets no response.
          if (mgr_psel_i[gnt_q]) begin
            mgr_pready_o[gnt_q]  = 1'b1;
            mgr_pslverr_o[gnt_q] = sub_pready_i ? sub_pslverr_i : 1'b1;
            mgr_prdata_o[gnt_q]  = sub_pready_i ? sub_prdata_i : '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef APB_ARB_TIMEOUT_EN
  localparam logic [15:0] TimeoutLast = 16'(TimeoutCycles - 1);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == SETUP) begin
      cnt_d = '0;
    end else if (state_q == ACCESS && !sub_pready_i) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the wait cycle that brings the count up to TimeoutCycles.
  assign timeout_hit = (state_q == ACCESS) && !sub_pready_i && (cnt_q == TimeoutLast);
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 32'(TimeoutCycles);
  assign timeout_hit        = 1'b0;
`endif

endmodule

// File: tb/tb_zeroheti_apb_arb.sv
// Randomized bench for zeroheti_apb_arb against a transaction-level arbiter model.
// Covers the timeout path when APB_ARB_TIMEOUT_EN is defined, the stall path otherwise.
module tb_zeroheti_apb_arb;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic                clk;
  logic                rst_n;
  logic [1:0]          mgr_psel;
  logic [1:0]          mgr_penable;
  logic [1:0]          mgr_pwrite;
  logic [1:0][AW-1:0]  mgr_paddr;
  logic [1:0][DW-1:0]  mgr_pwdata;
  logic [1:0][DW-1:0]  mgr_prdata;
  logic [1:0]          mgr_pready;
  logic [1:0]          mgr_pslverr;
  logic                sub_psel;
  logic                sub_penable;
  logic                sub_pwrite;
  logic [AW-1:0]       sub_paddr;
  logic [DW-1:0]       sub_pwdata;
  logic [DW-1:0]       sub_prdata;
  logic                sub_pready;
  logic                sub_pslverr;
  logic                timeout;
  logic [1:0]          dbg_state_unused;

  zeroheti_apb_arb #(
    .AddrWidth    (AW),
    .DataWidth    (DW),
    .TimeoutCycles(TO)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .mgr_psel_i   (mgr_psel),
    .mgr_penable_i(mgr_penable),
    .mgr_pwrite_i (mgr_pwrite),
    .mgr_paddr_i  (mgr_paddr),
    .mgr_pwdata_i (mgr_pwdata),
    .mgr_prdata_o (mgr_prdata),
    .mgr_pready_o (mgr_pready),
    .mgr_pslverr_o(mgr_pslverr),
    .sub_psel_o   (sub_psel),
    .sub_penable_o(sub_penable),
    .sub_pwrite_o (sub_pwrite),
    .sub_paddr_o  (sub_paddr),
    .sub_pwdata_o (sub_pwdata),
    .sub_prdata_i (sub_prdata),
    .sub_pready_i (sub_pready),
    .sub_pslverr_i(sub_pslverr),
    .timeout_o    (timeout),
    .state_o      (dbg_state_unused)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];
  bit  ptr;                 // model: index granted by the last completed transfer
  logic [DW-1:0] rsp_data;  // subordinate response for the next completion
  logic          rsp_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic chk_idle(input string tag);
    check({tag, "_sub_psel"}, 64'(sub_psel), 64'd0);
    check({tag, "_sub_penable"}, 64'(sub_penable), 64'd0);
    check({tag, "_sub_bus"}, 64'({sub_pwrite, sub_paddr} | 33'(sub_pwdata)), 64'd0);
    check({tag, "_mgr_pready"}, 64'(mgr_pready), 64'd0);
    check({tag, "_mgr_pslverr"}, 64'(mgr_pslverr), 64'd0);
    check({tag, "_mgr_prdata"}, 64'(mgr_prdata), 64'd0);
    check({tag, "_timeout"}, 64'(timeout), 64'd0);
  endtask

  task automatic chk_bus(input string tag, input int g, input bit pen);
    check({tag, "_sub_psel"}, 64'(sub_psel), 64'd1);
    check({tag, "_sub_penable"}, 64'(sub_penable), 64'(pen));
    check({tag, "_sub_paddr"}, 64'(sub_paddr), 64'(mgr_paddr[g]));
    check({tag, "_sub_pwdata"}, 64'(sub_pwdata), 64'(mgr_pwdata[g]));
    check({tag, "_sub_pwrite"}, 64'(sub_pwrite), 64'(mgr_pwrite[g]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic rand_mgr();
    for (int i = 0; i < 2; i++) begin
      mgr_paddr[i]  = $urandom;
      mgr_pwdata[i] = $urandom;
      mgr_pwrite[i] = 1'($urandom_range(0, 1));
    end
    rsp_data = $urandom;
    rsp_err  = 1'($urandom_range(0, 1));
  endtask

  task automatic release_bus();
    mgr_psel    = 2'b00;
    mgr_penable = 2'b00;
    sub_pready  = 1'b0;
    sub_pslverr = 1'b0;
    sub_prdata  = '0;
  endtask

  // One arbitrated transfer starting in an IDLE cycle, called on a falling edge.
  task automatic run_xfer(input logic [1:0] req, input int waits, input bit drop, input bit late);
    int g;
    logic [1:0] mask;
    logic [DW-1:0] exp_rd;
    g = (req == 2'b11) ? int'(!ptr) : int'(req[1]);
    if (!drop) exp_q.push_back(8'(g));
    mgr_psel    = req;
    mgr_penable = 2'b00;
    sub_pready  = 1'b0;
    sub_prdata  = $urandom;
    #1 chk_idle("idle");
    @(negedge clk);
    if (late) mgr_psel = 2'b11;
    #1 chk_bus("setup", g, 1'b0);
    check("setup_mgr_pready", 64'(mgr_pready), 64'd0);
    mgr_penable = mgr_psel;
    for (int w = 0; w <= waits; w++) begin
      @(negedge clk);
      sub_pready  = (w == waits);
      sub_prdata  = (w == waits) ? rsp_data : DW'($urandom);
      sub_pslverr = (w == waits) ? rsp_err : 1'($urandom_range(0, 1));
      if (w == waits && drop) mgr_psel[g] = 1'b0;
      #1 chk_bus("access", g, 1'b1);
      mask = (w == waits && !drop) ? 2'(1 << g) : 2'b00;
      check("access_mgr_pready", 64'(mgr_pready), 64'(mask));
      check("access_mgr_pslverr", 64'(mgr_pslverr), 64'(rsp_err ? mask : 2'b00));
      for (int i = 0; i < 2; i++) begin
        exp_rd = mask[i] ? rsp_data : '0;
        check($sformatf("access_mgr_prdata%0d", i), 64'(mgr_prdata[i]), 64'(exp_rd));
      end
      check("access_timeout", 64'(timeout), 64'd0);
      if (mask != 2'b00) begin
        if (exp_q.size() == 0) check("grant_queue_empty", 64'd1, 64'd0);
        else check("grant_order", 64'(mgr_pready == 2'b10 ? 1 : 0), 64'(exp_q.pop_front()));
      end
    end
    ptr = bit'(g);
    @(negedge clk);
    release_bus();
  endtask

`ifdef APB_ARB_TIMEOUT_EN
  task automatic run_timeout();
    rand_mgr();
    exp_q.push_back(8'd0);
    mgr_psel = 2'b01;
    #1 chk_idle("to_idle");
    @(negedge clk);
    #1 chk_bus("to_setup", 0, 1'b0);
    mgr_penable = 2'b01;
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      sub_pready = 1'b0;
      sub_prdata = $urandom;
      #1;
      if (k == TO || k == 1 || k == TO - 1) begin
        check($sformatf("to_pready_k%0d", k), 64'(mgr_pready), (k == TO) ? 64'd1 : 64'd0);
        check($sformatf("to_pslverr_k%0d", k), 64'(mgr_pslverr), (k == TO) ? 64'd1 : 64'd0);
        check($sformatf("to_pulse_k%0d", k), 64'(timeout), (k == TO) ? 64'd1 : 64'd0);
        check($sformatf("to_prdata_k%0d", k), 64'(mgr_prdata), 64'd0);
      end
      if (k == TO && mgr_pready == 2'b01) check("to_grant", 64'd0, 64'(exp_q.pop_front()));
    end
    ptr = 1'b0;
    @(negedge clk);
    #1 chk_idle("post_timeout");
    release_bus();
  endtask
`endif

  // Manager 1 transfer stalled in ACCESS, then reset pulled mid-cycle.
  task automatic reset_mid(input int hold);
    int done_cnt;
    rand_mgr();
    mgr_psel = 2'b10;
    #1 chk_idle("rm_idle");
    @(negedge clk);
    #1 chk_bus("rm_setup", 1, 1'b0);
    mgr_penable = 2'b10;
    done_cnt = 0;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      sub_pready = 1'b0;
      sub_prdata = $urandom;
      #1 if (mgr_pready != 2'b00 || timeout) done_cnt++;
    end
    check("stall_no_completion", 64'(done_cnt), 64'd0);
    chk_bus("rm_access", 1, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_idle("rst_async");
    release_bus();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ptr = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n       = 1'b0;
    mgr_paddr   = '0;
    mgr_pwdata  = '0;
    mgr_pwrite  = '0;
    rsp_data    = '0;
    rsp_err     = 1'b0;
    release_bus();
    mgr_psel    = 2'b11;
    sub_pready  = 1'b1;
    ptr         = 1'b1;
    repeat (2) @(negedge clk);
    #1 chk_idle("reset");
    release_bus();
    rst_n = 1'b1;

    // Ties held across four transfers after reset alternate 0,1,0,1.
    for (int t = 0; t < 4; t++) begin
      rand_mgr();
      run_xfer(2'b11, t, 1'b0, 1'b0);
    end

    // Manager 0 writes 0xA5 to 0x3000 with no wait states.
    rand_mgr();
    mgr_paddr[0]  = 32'h0000_3000;
    mgr_pwdata[0] = 32'hA5;
    mgr_pwrite[0] = 1'b1;
    rsp_err       = 1'b0;
    run_xfer(2'b01, 0, 1'b0, 1'b0);

    // Manager 1 reads 0xDEADBEEF after three wait states.
    rand_mgr();
    mgr_pwrite[1] = 1'b0;
    rsp_data      = 32'hDEAD_BEEF;
    rsp_err       = 1'b0;
    run_xfer(2'b10, 3, 1'b0, 1'b0);

    // Abandoned request still finishes on the bus and updates the pointer.
    rand_mgr();
    run_xfer(2'b11, 1, 1'b1, 1'b0);
    rand_mgr();
    run_xfer(2'b11, 0, 1'b0, 1'b1);

    for (int t = 0; t < 40; t++) begin
      rand_mgr();
      run_xfer(2'($urandom_range(1, 3)), $urandom_range(0, 4),
               ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
    end

`ifdef APB_ARB_TIMEOUT_EN
    run_timeout();
    reset_mid(5);
`else
    reset_mid(1000);
`endif

    // After reset the pointer is back to 1, so a tie grants manager 0.
    rand_mgr();
    run_xfer(2'b11, 0, 1'b0, 1'b0);
    rand_mgr();
    run_xfer(2'b11, 2, 1'b0, 1'b0);

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so a wedged DUT still reaches the summary line.
  initial begin
    #400000;
    check("watchdog_timeout", 64'd1, 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
